// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand front-end for the bit-serial adder: accepts (a, b)
// pairs over valid/ready and streams them LSB-first with first/last framing.
module serial_operand_feeder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] sh_a_r, sh_a_s;
  logic [WIDTH-1:0] sh_b_r, sh_b_s;
  logic [WIDTH-1:0] pend_a_r, pend_a_s;
  logic [WIDTH-1:0] pend_b_r, pend_b_s;
  logic             pend_full_r, pend_full_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             accept_s;

  assign accept_s = in_valid & !pend_full_r;

  // Next-state: shift, pending capture, and word-boundary reload selection
  always_comb begin
    state_s     = state_r;
    sh_a_s      = sh_a_r;
    sh_b_s      = sh_b_r;
    pend_a_s    = pend_a_r;
    pend_b_s    = pend_b_r;
    pend_full_s = pend_full_r;
    cnt_s       = cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          sh_a_s  = in_a;
          sh_b_s  = in_b;
          cnt_s   = {CW{1'b0}};
          state_s = SHIFT;
        end else begin
          cnt_s   = {CW{1'b0}};
        end
      end
      SHIFT: begin
        if (cnt_r != LAST_CNT) begin
          sh_a_s = {1'b0, sh_a_r[WIDTH-1:1]};
          sh_b_s = {1'b0, sh_b_r[WIDTH-1:1]};
          cnt_s  = cnt_r + CW'(1'b1);
          if (accept_s) begin
            pend_a_s    = in_a;
            pend_b_s    = in_b;
            pend_full_s = 1'b1;
          end else begin
            pend_full_s = pend_full_r;
          end
        end else if (pend_full_r) begin
          // Pending pair takes priority; in_ready is low so nothing new can land
          sh_a_s      = pend_a_r;
          sh_b_s      = pend_b_r;
          pend_full_s = 1'b0;
          cnt_s       = {CW{1'b0}};
        end else if (accept_s) begin
          sh_a_s = in_a;
          sh_b_s = in_b;
          cnt_s  = {CW{1'b0}};
        end else begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
        end
      end
      default: begin
        state_s     = IDLE;
        pend_full_s = 1'b0;
        cnt_s       = {CW{1'b0}};
      end
    endcase
  end

  // State and datapath registers; reset aborts any word and drops the pending pair
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      sh_a_r      <= {WIDTH{1'b0}};
      sh_b_r      <= {WIDTH{1'b0}};
      pend_a_r    <= {WIDTH{1'b0}};
      pend_b_r    <= {WIDTH{1'b0}};
      pend_full_r <= 1'b0;
      cnt_r       <= {CW{1'b0}};
    end else begin
      state_r     <= state_s;
      sh_a_r      <= sh_a_s;
      sh_b_r      <= sh_b_s;
      pend_a_r    <= pend_a_s;
      pend_b_r    <= pend_b_s;
      pend_full_r <= pend_full_s;
      cnt_r       <= cnt_s;
    end
  end

  // Output decode from registered state only; no path from in_a/in_b
  always_comb begin
    ser_valid = 1'b0;
    ser_a     = 1'b0;
    ser_b     = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    in_ready  = !pend_full_r;
    busy      = (state_r == SHIFT) | pend_full_r;
    if (state_r == SHIFT) begin
      ser_valid = 1'b1;
      ser_a     = sh_a_r[0];
      ser_b     = sh_b_r[0];
      ser_first = (cnt_r == {CW{1'b0}});
      ser_last  = (cnt_r == LAST_CNT);
    end else begin
      ser_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Scoreboard bench: stimulus pushes accepted operand pairs, a negedge monitor
// checks each serial bit and its framing against the queued pairs.
module tb_serial_operand_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [3:0] in_a, in_b;
  logic       ser_a, ser_b, ser_valid, ser_first, ser_last, busy;

  logic       in8_valid, in8_ready;
  logic [7:0] in8_a, in8_b;
  logic       ser8_a, ser8_b, ser8_valid, ser8_first, ser8_last, busy8;

  int checks = 0;
  int errors = 0;

  logic [3:0] q_a[$];
  logic [3:0] q_b[$];

  always #5 clk = ~clk;

  serial_operand_feeder #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .ser_a(ser_a), .ser_b(ser_b),
    .ser_valid(ser_valid), .ser_first(ser_first), .ser_last(ser_last), .busy(busy)
  );

  serial_operand_feeder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in8_valid), .in_ready(in8_ready),
    .in_a(in8_a), .in_b(in8_b), .ser_a(ser8_a), .ser_b(ser8_b),
    .ser_valid(ser8_valid), .ser_first(ser8_first), .ser_last(ser8_last), .busy(busy8)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Offer a pair, wait (bounded) for in_ready, and record it once accepted.
  task automatic send4(input logic [3:0] a, input logic [3:0] b, output int waited);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    waited = 0;
    while (!in_ready && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 8'd0, 8'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      q_a.push_back(a);
      q_b.push_back(b);
      #1;
    end
  endtask

  // Deassert valid and scramble the operand lines; they must have no effect.
  task automatic idle4();
    in_valid = 1'b0;
    in_a = 4'($urandom);
    in_b = 4'($urandom);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int  pos = 0;
  logic [3:0] cur_a, cur_b;
  logic have;

  // Monitor: compare every live serial bit against the head of the queue
  always @(negedge clk) begin
    if (!reset) begin
      pos = 0;
    end else begin
      if (q_a.size() > 0) chk("no_bubble", {7'd0, ser_valid}, 8'd1);
      if (ser_valid) begin
        if (pos == 0) begin
          have = (q_a.size() > 0);
          if (have) begin
            cur_a = q_a[0];
            cur_b = q_b[0];
          end else begin
            chk("unexpected_bit", 8'd1, 8'd0);
          end
        end
        if (have) begin
          chk("ser_a", {7'd0, ser_a}, {7'd0, cur_a[pos]});
          chk("ser_b", {7'd0, ser_b}, {7'd0, cur_b[pos]});
          chk("ser_first", {7'd0, ser_first}, {7'd0, pos == 0});
          chk("ser_last", {7'd0, ser_last}, {7'd0, pos == 3});
        end
        if (pos == 3) begin
          pos = 0;
          if (q_a.size() > 0) begin
            void'(q_a.pop_front());
            void'(q_b.pop_front());
          end
        end else begin
          pos++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  int w;
  logic [7:0] e8a, e8b;

  initial begin
    reset = 1'b0;
    in_valid = 1'b0; in_a = 4'd0; in_b = 4'd0;
    in8_valid = 1'b0; in8_a = 8'd0; in8_b = 8'd0;
    #12;
    chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_ser_valid", {7'd0, ser_valid}, 8'd0);
    @(negedge clk);
    reset = 1'b1;
    cycles(2);

    // Single word: A=1011 -> 1,1,0,1 ; B=0110 -> 0,1,1,0
    send4(4'b1011, 4'b0110, w);
    idle4();
    chk("t1_first", {7'd0, ser_first}, 8'd1);
    chk("t1_ser_a0", {7'd0, ser_a}, 8'd1);
    chk("t1_ser_b0", {7'd0, ser_b}, 8'd0);
    chk("t1_busy", {7'd0, busy}, 8'd1);
    cycles(3);
    chk("t1_last", {7'd0, ser_last}, 8'd1);
    cycles(1);
    chk("t1_valid_fall", {7'd0, ser_valid}, 8'd0);
    chk("t1_busy_fall", {7'd0, busy}, 8'd0);
    cycles(2);

    // Back-to-back via pending: (3,5), then (9,12) on the 2nd shift cycle, then (1,1)
    send4(4'd3, 4'd5, w);
    idle4();
    cycles(1);
    send4(4'd9, 4'd12, w);
    chk("t2_ready_drop", {7'd0, in_ready}, 8'd0);
    chk("t2_busy", {7'd0, busy}, 8'd1);
    send4(4'd1, 4'd1, w);
    chk("t2_wait_cycles", 8'(w), 8'd2);
    idle4();
    cycles(10);

    // Bypass at last bit: offer (15,0) only during ser_last
    send4(4'd2, 4'd3, w);
    idle4();
    cycles(3);
    chk("t3_at_last", {7'd0, ser_last}, 8'd1);
    send4(4'd15, 4'd0, w);
    idle4();
    chk("t3_wait_cycles", 8'(w), 8'd0);
    chk("t3_first", {7'd0, ser_first}, 8'd1);
    chk("t3_ser_a", {7'd0, ser_a}, 8'd1);
    chk("t3_ser_b", {7'd0, ser_b}, 8'd0);
    cycles(6);

    // Backpressure: pending full, (7,7) held until in_ready, emitted once
    send4(4'd3, 4'd3, w);
    send4(4'd6, 4'd6, w);
    send4(4'd7, 4'd7, w);
    idle4();
    chk("t4_wait_cycles", 8'(w), 8'd3);
    cycles(14);
    chk("t4_idle_again", {7'd0, busy}, 8'd0);

    // Reset mid-op during bit 2 with a pending word
    send4(4'd10, 4'd5, w);
    send4(4'd12, 4'd3, w);
    idle4();
    @(posedge clk);
    #2;
    reset = 1'b0;
    q_a.delete();
    q_b.delete();
    #1;
    chk("t5_valid_async", {7'd0, ser_valid}, 8'd0);
    chk("t5_ser_b_async", {7'd0, ser_b}, 8'd0);
    chk("t5_busy_async", {7'd0, busy}, 8'd0);
    chk("t5_ready_async", {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("t5_no_resume", {6'd0, ser_valid, ser_last}, 8'd0);
      chk("t5_busy_post", {6'd0, busy, !in_ready}, 8'd0);
    end

    // WIDTH=8: A5 -> 1,0,1,0,0,1,0,1 ; 3C -> 0,0,1,1,1,1,0,0 ; then bypass (81,7E)
    e8a = 8'hA5;
    e8b = 8'h3C;
    in8_valid = 1'b1; in8_a = 8'hA5; in8_b = 8'h3C;
    chk("w8_ready", {7'd0, in8_ready}, 8'd1);
    cycles(1);
    in8_valid = 1'b0; in8_a = 8'hFF; in8_b = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      chk("w8_valid", {7'd0, ser8_valid}, 8'd1);
      chk("w8_ser_a", {7'd0, ser8_a}, {7'd0, e8a[i]});
      chk("w8_ser_b", {7'd0, ser8_b}, {7'd0, e8b[i]});
      chk("w8_first", {7'd0, ser8_first}, {7'd0, i == 0});
      chk("w8_last", {7'd0, ser8_last}, {7'd0, i == 7});
      if (i == 7) begin
        in8_valid = 1'b1; in8_a = 8'h81; in8_b = 8'h7E;
      end
      cycles(1);
    end
    in8_valid = 1'b0;
    chk("w8_wrap_first", {7'd0, ser8_first}, 8'd1);
    chk("w8_wrap_a", {7'd0, ser8_a}, 8'd1);
    chk("w8_wrap_b", {7'd0, ser8_b}, 8'd0);
    cycles(7);
    chk("w8_wrap_last", {7'd0, ser8_last}, 8'd1);
    chk("w8_wrap_a7", {7'd0, ser8_a}, 8'd1);
    cycles(1);
    chk("w8_idle", {6'd0, ser8_valid, busy8}, 8'd0);

    cycles(2);
    chk("queue_drained", 8'(q_a.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
- Front-end for the bit-serial adder datapath.
- Accepts parallel operand pairs (a, b) through a valid/ready handshake and streams them LSB-first, one bit per cycle, as paired serial bits.
- Framing flags mark the first bit (downstream clears carry) and the last bit (downstream captures the result).
- A one-entry pending buffer lets a new pair be accepted while the current pair shifts, so sustained throughput is one pair per WIDTH cycles with no bubbles.

Parameters:
WIDTH, 4, operand width in bits; number of serial cycles per pair (legal range: >= 2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  input  1  upstream presents an operand pair
in_ready  output  1  block can accept a pair this cycle
in_a  input  WIDTH  operand A, sampled on accept
in_b  input  WIDTH  operand B, sampled on accept
ser_a  output  1  current serial bit of A, LSB first
ser_b  output  1  current serial bit of B, LSB first
ser_valid  output  1  ser_a/ser_b carry a live bit this cycle
ser_first  output  1  bit 0 of a word (downstream carry clear)
ser_last  output  1  bit WIDTH-1 of a word (downstream result capture)
busy  output  1  shifting or pending buffer occupied

Behaviour:
- Reset (reset=0, async):
  - State = IDLE; shift registers, pending buffer, pending_full and bit counter cleared.
  - Outputs: ser_* = 0, busy = 0, in_ready = 1.
  - Asserting reset mid-word aborts the word and discards any pending pair; no ser_last is issued for the aborted word.
- Handshake:
  - Accept = in_valid & in_ready, evaluated at the rising edge.
  - in_ready = !pending_full, combinational from state only and independent of in_valid.
- Internal state:
  - sh_a, sh_b (WIDTH bits each).
  - pend_a, pend_b, pending_full.
  - cnt, ceil(log2 WIDTH) bits.
  - FSM {IDLE, SHIFT}.
- IDLE:
  - ser_valid = 0; ser_a/ser_b/ser_first/ser_last = 0.
  - On accept: load sh_a/sh_b from the inputs, cnt = 0, go to SHIFT.
  - Latency: the first bit appears in the cycle after the accepting edge.
- SHIFT:
  - Outputs: ser_valid = 1, ser_a = sh_a[0], ser_b = sh_b[0], ser_first = (cnt == 0), ser_last = (cnt == WIDTH-1).
  - If cnt < WIDTH-1: shift sh_a/sh_b right by 1 and increment cnt. An accept in this cycle writes the pending buffer and sets pending_full.
  - If cnt == WIDTH-1, priority order:
    1. pending_full: load sh from pend, clear pending_full, cnt = 0, stay in SHIFT. in_ready was 0, so no accept is possible.
    2. Else accept this cycle: load sh directly from the inputs (bypass), cnt = 0, stay in SHIFT.
    3. Else: go to IDLE.
  - Back-to-back words therefore produce ser_last on one cycle and ser_first on the next, with ser_valid held at 1.
- busy = (state == SHIFT) | pending_full.
- Input values are irrelevant when in_valid = 0. Operands are captured only at accept; later changes on in_a/in_b have no effect.
- No combinational path from in_a/in_b to any output.

Test Plan:
- Single word: WIDTH=4, accept a=4'b1011, b=4'b0110 in IDLE → next 4 cycles: ser_a = 1,1,0,1 and ser_b = 0,1,1,0; ser_first on cycle 1, ser_last on cycle 4; ser_valid falls in cycle 5; busy goes 1→0.
- Back-to-back via pending:
  - Stimulus: accept (3,5), then on the 2nd shift cycle accept (9,12); hold in_valid with (1,1).
  - Required response: in_ready drops to 0 the cycle after the 2nd accept. Word 2 starts (ser_first) immediately after word 1's ser_last. in_ready returns to 1 on word 2's first cycle, and (1,1) is accepted there.
- Bypass at last bit: pending empty, in_valid asserted only during ser_last with (15,0) → next cycle ser_first = 1, ser_a = 1, ser_b = 0; no idle cycle.
- Backpressure hold: pending full, in_valid held high with (7,7) for 3 cycles → no accept until in_ready = 1; (7,7) is emitted exactly once.
- Reset mid-op: assert reset asynchronously during bit 2 with a pending word → outputs 0 immediately (before the next edge); after release in_ready = 1, busy = 0, and neither word resumes.
- WIDTH=8: a=8'hA5, b=8'h3C → 8 serial bits, LSB first, ser_last on the 8th bit; cnt wraps correctly.
